// File: rtl/pwm_update_scheduler.sv
// pwm_update_scheduler
// Four free-running PWM generators with shadowed duty/divider registers.
// New configuration is only adopted at a period wrap (or on sync_restart),
// so a waveform period is never cut short or stretched mid-way. Eight
// outputs each pick a generator, or are held statically high, and are
// registered before leaving the block.
module pwm_update_scheduler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_strobe,
  input  logic       sync_restart,
  input  logic [7:0] reg_en_out,
  input  logic [7:0] reg_en_pwm_out,
  input  logic [7:0] reg_out_3_0_pwm_chanel,
  input  logic [7:0] reg_out_7_4_pwm_chanel,
  input  logic [7:0] reg_pwm_gen_0_duty_cycle,
  input  logic [7:0] reg_pwm_gen_1_duty_cycle,
  input  logic [7:0] reg_pwm_gen_2_duty_cycle,
  input  logic [7:0] reg_pwm_gen_3_duty_cycle,
  input  logic [7:0] reg_pwm_gen_1_0_frequency_divider,
  input  logic [7:0] reg_pwm_gen_3_2_frequency_divider,
  output logic [7:0] pwm_out,
  output logic [3:0] period_start,
  output logic [3:0] update_done
);

  // Live (unshadowed) configuration, one entry per generator.
  logic [7:0] duty_in [4];
  logic [3:0] div_in  [4];

  // Per-generator running state.
  logic [3:0] presc_q   [4];
  logic [7:0] cnt_q     [4];
  logic [7:0] sh_duty_q [4];
  logic [3:0] sh_div_q  [4];
  logic [3:0] pending_q;

  // Per-generator events and raw waveform.
  logic [3:0] tick;
  logic [3:0] wrap;
  logic [3:0] load;
  logic [3:0] raw_pwm;

  // Two select bits per output, output 0 in the low bits.
  logic [15:0] sel_all;
  logic [7:0]  pwm_next;

  assign duty_in[0] = reg_pwm_gen_0_duty_cycle;
  assign duty_in[1] = reg_pwm_gen_1_duty_cycle;
  assign duty_in[2] = reg_pwm_gen_2_duty_cycle;
  assign duty_in[3] = reg_pwm_gen_3_duty_cycle;

  assign div_in[0] = reg_pwm_gen_1_0_frequency_divider[3:0];
  assign div_in[1] = reg_pwm_gen_1_0_frequency_divider[7:4];
  assign div_in[2] = reg_pwm_gen_3_2_frequency_divider[3:0];
  assign div_in[3] = reg_pwm_gen_3_2_frequency_divider[7:4];

  assign sel_all = {reg_out_7_4_pwm_chanel, reg_out_3_0_pwm_chanel};

  for (genvar g = 0; g < 4; g++) begin : g_evt
    // The prescaler reaching the shadow divider advances the period counter.
    assign tick[g] = (presc_q[g] == sh_div_q[g]);
    // Last tick of the period: counter about to roll from 255 to 0.
    assign wrap[g] = tick[g] && (cnt_q[g] == 8'hFF);
    // A strobe landing on the wrap itself loads immediately instead of
    // waiting a full period in the pending flag.
    assign load[g] = wrap[g] && (pending_q[g] || cfg_strobe);
    // Duty 255 means fully on; otherwise high while the counter is below duty.
    assign raw_pwm[g] = (sh_duty_q[g] == 8'hFF) || (cnt_q[g] < sh_duty_q[g]);
  end

  // Route each output to its selected generator, or hold it high in static mode.
  always_comb begin
    pwm_next = '0;
    for (int i = 0; i < 8; i++) begin
      pwm_next[i] = reg_en_out[i] &
                    (reg_en_pwm_out[i] ? raw_pwm[sel_all[2*i +: 2]] : 1'b1);
    end
  end

  // Prescalers and period counters; sync_restart realigns all generators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 4; g++) begin
        presc_q[g] <= '0;
        cnt_q[g]   <= '0;
      end
    end else if (sync_restart) begin
      for (int g = 0; g < 4; g++) begin
        presc_q[g] <= '0;
        cnt_q[g]   <= '0;
      end
    end else begin
      for (int g = 0; g < 4; g++) begin
        presc_q[g] <= tick[g] ? 4'd0 : presc_q[g] + 4'd1;
        if (tick[g]) begin
          cnt_q[g] <= cnt_q[g] + 8'd1;
        end
      end
    end
  end

  // Shadow registers change only at a wrap with an update queued, or on restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 4; g++) begin
        sh_duty_q[g] <= '0;
        sh_div_q[g]  <= '0;
      end
    end else begin
      for (int g = 0; g < 4; g++) begin
        if (sync_restart || load[g]) begin
          sh_duty_q[g] <= duty_in[g];
          sh_div_q[g]  <= div_in[g];
        end
      end
    end
  end

  // Pending flags queue a strobe until the owning generator's next wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else if (sync_restart) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q | {4{cfg_strobe}}) & ~load;
    end
  end

  // Status pulses trail the event that caused them by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start <= '0;
      update_done  <= '0;
    end else if (sync_restart) begin
      period_start <= 4'hF;
      update_done  <= 4'hF;
    end else begin
      period_start <= wrap;
      update_done  <= load;
    end
  end

  // Output pins are registered so they never glitch on select/enable changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= pwm_next;
    end
  end

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Testbench for pwm_update_scheduler: directed stimulus, a position-in-period
// reference model compared every cycle, and hand-computed waveform checks.
module tb_pwm_update_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_strobe = 1'b0;
  logic       sync_restart = 1'b0;
  logic [7:0] en_out = 8'h00;
  logic [7:0] en_pwm = 8'h00;
  logic [7:0] sel30 = 8'h00;
  logic [7:0] sel74 = 8'h00;
  logic [7:0] duty_in [4];
  logic [3:0] div_in  [4];
  logic [7:0] div10;
  logic [7:0] div32;
  logic [7:0] pwm_out;
  logic [3:0] period_start;
  logic [3:0] update_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  assign div10 = {div_in[1], div_in[0]};
  assign div32 = {div_in[3], div_in[2]};

  pwm_update_scheduler dut (
    .clk                               (clk),
    .rst_n                             (rst_n),
    .cfg_strobe                        (cfg_strobe),
    .sync_restart                      (sync_restart),
    .reg_en_out                        (en_out),
    .reg_en_pwm_out                    (en_pwm),
    .reg_out_3_0_pwm_chanel            (sel30),
    .reg_out_7_4_pwm_chanel            (sel74),
    .reg_pwm_gen_0_duty_cycle          (duty_in[0]),
    .reg_pwm_gen_1_duty_cycle          (duty_in[1]),
    .reg_pwm_gen_2_duty_cycle          (duty_in[2]),
    .reg_pwm_gen_3_duty_cycle          (duty_in[3]),
    .reg_pwm_gen_1_0_frequency_divider (div10),
    .reg_pwm_gen_3_2_frequency_divider (div32),
    .pwm_out                           (pwm_out),
    .period_start                      (period_start),
    .update_done                       (update_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each generator is tracked as its position within the
  // current period; the level index is position / (divider + 1).
  int m_pos  [4];
  int m_duty [4];
  int m_div  [4];
  bit m_pend [4];
  logic [7:0]  e_pwm = 8'h00;
  logic [3:0]  e_ps  = 4'h0;
  logic [3:0]  e_ud  = 4'h0;
  logic [7:0]  m_nxt;
  logic [15:0] m_sel;
  int m_g;
  int m_len;

  function automatic bit model_raw(input int g);
    int level;
    level = m_pos[g] / (m_div[g] + 1);
    if (m_duty[g] == 255) return 1'b1;
    return (level < m_duty[g]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 4; g++) begin
        m_pos[g] = 0; m_duty[g] = 0; m_div[g] = 0; m_pend[g] = 1'b0;
      end
      e_pwm = 8'h00; e_ps = 4'h0; e_ud = 4'h0;
    end else begin
      m_sel = {sel74, sel30};
      for (int i = 0; i < 8; i++) begin
        m_g = int'(m_sel[2*i +: 2]);
        m_nxt[i] = en_out[i] && (!en_pwm[i] || model_raw(m_g));
      end
      for (int g = 0; g < 4; g++) begin
        if (sync_restart) begin
          m_pos[g] = 0;
          m_duty[g] = int'(duty_in[g]);
          m_div[g] = int'(div_in[g]);
          m_pend[g] = 1'b0;
          e_ps[g] = 1'b1;
          e_ud[g] = 1'b1;
        end else begin
          m_len = (m_div[g] + 1) * 256;
          e_ps[g] = (m_pos[g] == m_len - 1);
          e_ud[g] = 1'b0;
          if (e_ps[g]) begin
            m_pos[g] = 0;
            if (m_pend[g] || cfg_strobe) begin
              m_duty[g] = int'(duty_in[g]);
              m_div[g] = int'(div_in[g]);
              m_pend[g] = 1'b0;
              e_ud[g] = 1'b1;
            end
          end else begin
            m_pos[g] = m_pos[g] + 1;
            if (cfg_strobe) m_pend[g] = 1'b1;
          end
        end
      end
      e_pwm = m_nxt;
    end
  end

  // Every cycle, all outputs must match the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("model_pwm_out", 32'(pwm_out), 32'(e_pwm));
      chk("model_period_start", 32'(period_start), 32'(e_ps));
      chk("model_update_done", 32'(update_done), 32'(e_ud));
    end
  end

  // Sample pwm_out[0] for len cycles, optionally pulsing cfg_strobe at one of them.
  task automatic run_period(input int len, input int cfg_at, output int highs);
    highs = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      cfg_strobe = (k == cfg_at);
      if (pwm_out[0]) highs++;
    end
  endtask

  initial begin
    int highs;
    int ud_seen;
    for (int g = 0; g < 4; g++) begin
      duty_in[g] = 8'h00;
      div_in[g] = 4'h0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pwm_out", 32'(pwm_out), 0);
    chk("reset_period_start", 32'(period_start), 0);
    chk("reset_update_done", 32'(update_done), 0);
    rst_n = 1'b1;
    checking = 1'b1;

    // Static-high output 0, generators irrelevant.
    en_out = 8'h01;
    en_pwm = 8'h00;
    @(negedge clk);
    chk("static_out0", 32'(pwm_out), 32'h01);
    chk("no_update_after_release", 32'(update_done), 0);

    // gen0 duty 64 div 0; other generators and selects exercise routing.
    duty_in[0] = 8'd64;  div_in[0] = 4'd0;
    duty_in[1] = 8'd10;  div_in[1] = 4'd1;
    duty_in[2] = 8'd200; div_in[2] = 4'd2;
    duty_in[3] = 8'd255; div_in[3] = 4'd0;
    en_out = 8'hFF;
    en_pwm = 8'hBF;
    sel30 = 8'h9C;
    sel74 = 8'hC9;
    sync_restart = 1'b1;
    @(negedge clk);
    sync_restart = 1'b0;
    chk("sync_update_done", 32'(update_done), 32'hF);
    chk("sync_period_start", 32'(period_start), 32'hF);
    run_period(256, -1, highs);
    chk("d64_high_count", 32'(highs), 64);
    chk("d64_period_start", 32'(period_start[0]), 1);
    chk("d64_no_update", 32'(update_done[0]), 0);

    // Mid-period change to 192: current period unaffected.
    duty_in[0] = 8'd192;
    run_period(256, 100, highs);
    chk("midcfg_high_count", 32'(highs), 64);
    chk("midcfg_update_done", 32'(update_done[0]), 1);
    run_period(256, -1, highs);
    chk("d192_high_count", 32'(highs), 192);
    chk("d192_period_start", 32'(period_start[0]), 1);
    chk("d192_no_second_update", 32'(update_done[0]), 0);

    // Divider 3, duty 128: 1024-clock period, 512 high.
    duty_in[0] = 8'd128;
    div_in[0] = 4'd3;
    run_period(256, 10, highs);
    chk("pre_div3_high_count", 32'(highs), 192);
    chk("div3_update_done", 32'(update_done[0]), 1);
    run_period(1024, -1, highs);
    chk("div3_high_count", 32'(highs), 512);
    chk("div3_period_start", 32'(period_start[0]), 1);

    // Duty 255 is constant high.
    duty_in[0] = 8'd255;
    run_period(1024, 500, highs);
    chk("pre_d255_high_count", 32'(highs), 512);
    run_period(1024, -1, highs);
    chk("d255_high_count", 32'(highs), 1024);

    // Duty 0 is constant low.
    duty_in[0] = 8'd0;
    run_period(1024, 300, highs);
    chk("pre_d0_high_count", 32'(highs), 1024);
    run_period(1024, -1, highs);
    chk("d0_high_count", 32'(highs), 0);

    // Strobe exactly on the wrap cycle: used in the very next period.
    duty_in[0] = 8'd32;
    div_in[0] = 4'd0;
    run_period(1024, 1022, highs);
    chk("wrapcfg_old_high_count", 32'(highs), 0);
    chk("wrapcfg_update_done", 32'(update_done[0]), 1);
    run_period(256, -1, highs);
    chk("wrapcfg_new_high_count", 32'(highs), 32);
    chk("wrapcfg_period_start", 32'(period_start[0]), 1);
    chk("wrapcfg_no_second_update", 32'(update_done[0]), 0);

    // Reset mid-period with an update pending.
    duty_in[0] = 8'd100;
    run_period(50, 5, highs);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_pwm_out", 32'(pwm_out), 0);
    chk("async_reset_period_start", 32'(period_start), 0);
    chk("async_reset_update_done", 32'(update_done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ud_seen = 0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (update_done != 4'h0) ud_seen++;
    end
    chk("no_update_after_reset", 32'(ud_seen), 0);
    chk("post_reset_only_static", 32'(pwm_out), 32'h40);

    sync_restart = 1'b1;
    @(negedge clk);
    sync_restart = 1'b0;
    chk("final_sync_update_done", 32'(update_done), 32'hF);
    repeat (4) @(negedge clk);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_update_scheduler.md
PWM_UPDATE_SCHEDULER -- requirements
Module: pwm_update_scheduler

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 clk  input  1  system clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cfg_strobe  input  1  one-cycle pulse; any configuration register was just written.
REQ-005 sync_restart  input  1  one-cycle pulse; restart all generators in phase.
REQ-006 reg_en_out  input  8  per-output enable.
REQ-007 reg_en_pwm_out  input  8  per-output PWM mode (1 = PWM, 0 = static high).
REQ-008 reg_out_3_0_pwm_chanel  input  8  generator select, 2 bits per output 0..3 (bits [2i+1:2i]).
REQ-009 reg_out_7_4_pwm_chanel  input  8  generator select, 2 bits per output 4..7.
REQ-010 reg_pwm_gen_0..3_duty_cycle  input  8 each  duty cycle of generators 0..3.
REQ-011 reg_pwm_gen_1_0_frequency_divider  input  8  [3:0] = gen0 divider, [7:4] = gen1 divider.
REQ-012 reg_pwm_gen_3_2_frequency_divider  input  8  [3:0] = gen2 divider, [7:4] = gen3 divider.
REQ-013 pwm_out  output  8  registered output pins.
REQ-014 period_start  output  4  per-generator one-cycle pulse at each period boundary.
REQ-015 update_done  output  4  per-generator one-cycle pulse when shadow registers load.

Function
REQ-016 Each generator g SHALL own a 4-bit prescaler, an 8-bit period counter cnt_g, an 8-bit shadow duty, a 4-bit shadow divider and a pending flag.
REQ-017 Prescaler SHALL count 0..sh_div; a tick SHALL occur on the cycle prescaler equals sh_div, and the prescaler returns to 0 on that same cycle (period = (sh_div+1)*256 clk).
REQ-018 On each tick cnt_g SHALL increment by 1, modulo 256; wrap event = tick with cnt_g == 255.
REQ-019 Raw PWM for g SHALL be 1 when sh_duty == 255, else (cnt_g < sh_duty); duty 0 gives constant 0.
REQ-020 cfg_strobe SHALL set pending for all four generators.
REQ-021 On a wrap event with pending or cfg_strobe asserted, sh_duty and sh_div SHALL load from the current inputs, pending SHALL clear, and update_done[g] SHALL pulse on the next cycle.
REQ-022 cfg_strobe coinciding with a wrap event SHALL load in that cycle and leave pending clear.
REQ-023 Shadow registers SHALL never change except at a wrap event, on sync_restart, or at reset (glitch-free updates).
REQ-024 sync_restart SHALL have priority over cfg_strobe and wrap: all prescalers and counters go to 0, all shadows load from inputs, all pending clear, update_done = 4'b1111 and period_start = 4'b1111 on the next cycle.
REQ-025 period_start[g] SHALL pulse one cycle after each wrap event of g.
REQ-026 pwm_out[i] SHALL register, with 1-clk latency, reg_en_out[i] AND (reg_en_pwm_out[i] ? raw PWM of selected generator : 1).
REQ-027 Enable, mode and channel-select inputs SHALL be unshadowed and take effect with 1-clk latency.

Reset
REQ-028 On rst_n low, all prescalers, counters, shadows and pending flags SHALL clear to 0, and pwm_out, period_start and update_done SHALL be 0, asynchronously.
REQ-029 After reset release, generators SHALL run with divider 0 and duty 0 until the first shadow load.
REQ-030 Reset asserted mid-period SHALL discard pending updates; no update_done pulse follows reset.

Verification
REQ-031 reg_en_out=0x01, reg_en_pwm_out=0x00 -> pwm_out=0x01 one clk later, irrespective of generators.
REQ-032 Set gen0 duty=64, div=0, out0 PWM on gen0, sync_restart -> pwm_out[0] high 64 clk, low 192 clk, period_start[0] every 256 clk.
REQ-033 Running duty=64, change duty to 192 with cfg_strobe mid-period -> waveform unchanged until wrap, update_done[0] one clk after wrap, next period high 192 clk.
REQ-034 div nibble=3, duty=128 -> period 1024 clk, high 512 clk; duty=255 -> constant high; duty=0 -> constant low.
REQ-035 cfg_strobe on the exact wrap cycle -> new values used in the immediately following period, pending clear, no second update_done at the next wrap.
REQ-036 rst_n pulsed low mid-period with pending set -> all outputs 0 immediately; after release no update_done until next cfg_strobe/sync_restart.
